// File: rtl/procedural_construct_as.sv
// -----------------------------------------------------------------------------
// procedural_construct_as
//
// Registered N-bit add/subtract unit built on a bitwise ripple-carry chain.
// Subtraction is A + ~B + 1: B is inverted by Op and Op also feeds the
// chain's carry-in, so a single adder serves both operations.
//
// Parameters
//   N          operand/result width in bits (N >= 2)
//
// Ports
//   clk        system clock, all state updates on its rising edge
//   rst        synchronous, active-high reset
//   A, B       N-bit operands (two's complement or unsigned)
//   Op         0 = A+B, 1 = A-B
//   in_valid   A, B and Op are sampled on an edge where in_valid=1
//   S          registered N-bit result (modulo 2^N)
//   Cout       registered carry out of the MSB stage
//                (add: unsigned overflow, subtract: 1 = no borrow)
//   V          registered two's-complement overflow flag
//   out_valid  S, Cout and V hold a result produced on the previous edge
// -----------------------------------------------------------------------------
module procedural_construct_as #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Op,
  input  logic         in_valid,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         V,
  output logic         out_valid
);

  // One full-adder stage: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic sum_v;
    logic carry_v;
    sum_v   = a ^ b ^ c;
    carry_v = (a & b) | (c & (a ^ b));
    return {carry_v, sum_v};
  endfunction

  logic [N-1:0] b_s;        // B conditionally inverted by Op
  logic [N-1:0] sum_s;      // combinational result bits
  logic [1:0]   stage_s;    // {carry, sum} of the stage being evaluated
  logic         carry_s;    // running carry through the chain
  logic         c_msb_s;    // carry into the MSB stage, c_(N-1)
  logic         c_out_s;    // carry out of the MSB stage, c_N

  logic [N-1:0] s_r;
  logic         cout_r;
  logic         v_r;
  logic         out_valid_r;

  // Ripple-carry chain; the running carry is threaded through a single
  // variable so no combinational vector feeds back on itself.
  always_comb begin
    b_s     = B ^ {N{Op}};
    sum_s   = {N{1'b0}};
    stage_s = 2'b00;
    carry_s = Op;
    c_msb_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      // Last value captured here is the carry entering stage N-1.
      c_msb_s  = carry_s;
      stage_s  = full_add(A[i], b_s[i], carry_s);
      sum_s[i] = stage_s[0];
      carry_s  = stage_s[1];
    end
    c_out_s = carry_s;
  end

  // Result register: reset wins over a presented transaction; without a
  // transaction the result holds and only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r         <= {N{1'b0}};
      cout_r      <= 1'b0;
      v_r         <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        s_r    <= sum_s;
        cout_r <= c_out_s;
        v_r    <= c_out_s ^ c_msb_s;
      end else begin
        s_r    <= s_r;
        cout_r <= cout_r;
        v_r    <= v_r;
      end
    end
  end

  assign S         = s_r;
  assign Cout      = cout_r;
  assign V         = v_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_procedural_construct_as.sv
// -----------------------------------------------------------------------------
// tb_procedural_construct_as
//
// Directed bench for procedural_construct_as. One instance at the default
// width (N=12) and one at N=6 share clock and reset. Expected values are
// hand-computed constants, plus an arithmetic reference for the full N=6 sweep.
// -----------------------------------------------------------------------------
module tb_procedural_construct_as;

  logic        clk;
  logic        rst;

  logic [11:0] a12;
  logic [11:0] b12;
  logic        op12;
  logic        iv12;
  logic [11:0] s12;
  logic        c12;
  logic        v12;
  logic        ov12;

  logic [5:0]  a6;
  logic [5:0]  b6;
  logic        op6;
  logic        iv6;
  logic [5:0]  s6;
  logic        c6;
  logic        v6;
  logic        ov6;

  int n_checks;
  int n_fail;

  procedural_construct_as dut12 (
    .clk(clk), .rst(rst), .A(a12), .B(b12), .Op(op12), .in_valid(iv12),
    .S(s12), .Cout(c12), .V(v12), .out_valid(ov12)
  );

  procedural_construct_as #(.N(6)) dut6 (
    .clk(clk), .rst(rst), .A(a6), .B(b6), .Op(op6), .in_valid(iv6),
    .S(s6), .Cout(c6), .V(v6), .out_valid(ov6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive6(input logic [5:0] a, input logic [5:0] b, input logic op, input logic iv);
    a6  = a;
    b6  = b;
    op6 = op;
    iv6 = iv;
  endtask

  // Compare {S, Cout, V, out_valid} of the N=6 instance.
  task automatic expect6(input string tag, input logic [5:0] s, input logic c, input logic v, input logic ov);
    check(tag, {23'd0, s6, c6, v6, ov6}, {23'd0, s, c, v, ov});
  endtask

  logic [6:0] full;
  logic [5:0] ref_s;
  logic       ref_v;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    a12  = 12'd0; b12 = 12'd0; op12 = 1'b0; iv12 = 1'b0;
    drive6(6'b000000, 6'b000000, 1'b0, 1'b0);
    step();
    step();

    // Reset state
    expect6("reset6", 6'b000000, 1'b0, 1'b0, 1'b0);
    check("reset12", {19'd0, s12, c12, v12, ov12}, 32'd0);
    rst = 1'b0;

    // N=12 subtract with borrow: 125 - (-65 signed / 4031 unsigned)
    a12 = 12'b000001111101; b12 = 12'b111110111111; op12 = 1'b1; iv12 = 1'b1;
    step();
    check("n12_sub", {19'd0, s12, c12, v12, ov12}, {19'd0, 12'b000010111110, 1'b0, 1'b0, 1'b1});
    iv12 = 1'b0;
    step();
    check("n12_hold", {19'd0, s12, c12, v12, ov12}, {19'd0, 12'b000010111110, 1'b0, 1'b0, 1'b0});

    // Back-to-back stream with Op changing between transactions
    drive6(6'b100011, 6'b011010, 1'b0, 1'b1);
    step();
    expect6("stream0", 6'b111101, 1'b0, 1'b0, 1'b1);
    drive6(6'b010110, 6'b001001, 1'b1, 1'b1);
    step();
    expect6("stream1", 6'b001101, 1'b1, 1'b0, 1'b1);
    drive6(6'b111111, 6'b000001, 1'b0, 1'b1);
    step();
    expect6("stream2", 6'b000000, 1'b1, 1'b0, 1'b1);
    drive6(6'b101010, 6'b010101, 1'b1, 1'b0);
    step();
    expect6("stream_idle", 6'b000000, 1'b1, 1'b0, 1'b0);

    // Overflow cases
    drive6(6'b011011, 6'b010101, 1'b0, 1'b1);
    step();
    expect6("ovf_add", 6'b110000, 1'b0, 1'b1, 1'b1);
    drive6(6'b110001, 6'b001001, 1'b1, 1'b1);
    step();
    expect6("neg_sub", 6'b101000, 1'b1, 1'b0, 1'b1);
    drive6(6'b100000, 6'b000001, 1'b1, 1'b1);
    step();
    expect6("most_neg", 6'b011111, 1'b1, 1'b1, 1'b1);
    drive6(6'b101010, 6'b101010, 1'b1, 1'b1);
    step();
    expect6("a_eq_b", 6'b000000, 1'b1, 1'b0, 1'b1);
    drive6(6'b011111, 6'b011111, 1'b0, 1'b1);
    step();
    expect6("pos_ovf", 6'b111110, 1'b0, 1'b1, 1'b1);

    // Reset mid-stream: the presented vector must be dropped
    rst = 1'b1;
    drive6(6'b000111, 6'b000001, 1'b0, 1'b1);
    step();
    expect6("rst_mid", 6'b000000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive6(6'b000111, 6'b000001, 1'b0, 1'b0);
    step();
    expect6("rst_drop", 6'b000000, 1'b0, 1'b0, 1'b0);
    drive6(6'b000111, 6'b000001, 1'b0, 1'b1);
    step();
    expect6("post_rst", 6'b001000, 1'b0, 1'b0, 1'b1);

    // Full sweep at N=6, streamed at one transaction per edge
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < 64; a++) begin
        for (int b = 0; b < 64; b++) begin
          drive6(a[5:0], b[5:0], op[0], 1'b1);
          step();
          if (op == 0) begin
            full  = {1'b0, a[5:0]} + {1'b0, b[5:0]};
            ref_s = full[5:0];
            ref_v = (a[5] == b[5]) && (ref_s[5] != a[5]);
          end else begin
            full  = {1'b0, a[5:0]} + {1'b0, ~b[5:0]} + 7'd1;
            ref_s = full[5:0];
            ref_v = (a[5] != b[5]) && (ref_s[5] != a[5]);
          end
          expect6("sweep", ref_s, full[6], ref_v, 1'b1);
        end
      end
    end

    iv6 = 1'b0;
    step();
    expect6("sweep_end", ref_s, full[6], ref_v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/procedural_construct_as.md
PROCEDURAL_CONSTRUCT_AS -- requirements
Module: procedural_construct_as

Interface
REQ-001 The block SHALL have one parameter: N, default 12, operand and result width in bits, legal range N >= 2.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk SHALL be an input of width 1: the system clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: the synchronous, active-high reset.
REQ-005 Port A SHALL be an input of width N: operand A, two's complement or unsigned.
REQ-006 Port B SHALL be an input of width N: operand B, two's complement or unsigned.
REQ-007 Port Op SHALL be an input of width 1: operation select; 0 = add (A+B), 1 = subtract (A-B).
REQ-008 Port in_valid SHALL be an input of width 1: A, B and Op are sampled on a rising edge where in_valid=1.
REQ-009 Port S SHALL be an output of width N: the registered result.
REQ-010 Port Cout SHALL be an output of width 1: the registered carry-out of the MSB stage.
REQ-011 Port V SHALL be an output of width 1: the registered signed-overflow flag.
REQ-012 Port out_valid SHALL be an output of width 1: S, Cout and V hold a fresh result.

Function
REQ-013 The datapath SHALL compute A + (B XOR {N{Op}}) + Op.
- Op is the carry-in of a bitwise ripple-carry chain.
- Stage i: sum_i = a_i ^ b'_i ^ c_i; c_(i+1) = a_i&b'_i | c_i&(a_i^b'_i).
- b'_i = b_i ^ Op; c_0 = Op.
REQ-014 S SHALL equal the low N bits of the result; wrap-around is modulo 2^N.
REQ-015 Cout SHALL equal c_N.
- Add: Cout=1 means unsigned overflow.
- Subtract: Cout=1 means no borrow (A >= B unsigned); Cout=0 means borrow.
REQ-016 V SHALL equal c_N XOR c_(N-1), i.e. two's-complement overflow for both add and subtract.
REQ-017 Latency SHALL be exactly 1 cycle: a transaction sampled at edge k updates S, Cout and V and sets out_valid=1 after edge k.
REQ-018 On an edge with in_valid=0 and rst=0:
- S, Cout and V SHALL hold their previous values.
- out_valid SHALL go to 0.
REQ-019 Back-to-back transactions (in_valid=1 on every edge) SHALL be accepted at full throughput, one result per cycle, with no stall.
REQ-020 Op SHALL be evaluated per transaction; a change of Op between consecutive transactions SHALL NOT affect the earlier result.
REQ-021 A=B with Op=1 SHALL yield S=0, Cout=1, V=0.
REQ-022 Most-negative operand cases SHALL follow REQ-016 without special-casing.
- Example: N=6, A=100000, B=000001, Op=1 -> S=011111, V=1.

Reset
REQ-023 When rst=1 at a rising edge, the following SHALL be 0 after that edge: S, Cout, V and out_valid.
REQ-024 rst SHALL take priority over in_valid; a transaction presented on a reset edge SHALL be discarded.
REQ-025 A result held from before reset SHALL be lost; the first result after reset SHALL come from the first in_valid=1 edge with rst=0.

Verification
REQ-026 N=12, A=000001111101, B=111110111111, Op=1, in_valid=1 -> next cycle: S=000010111110 (190), Cout=0, V=0, out_valid=1.
REQ-027 N=6 scenarios, each with in_valid=1, required response one cycle later:
- A=100011 (-29), B=011010 (26), Op=0 -> S=111101 (-3), Cout=0, V=0.
- A=010110 (22), B=001001 (9), Op=1 -> S=001101 (13), Cout=1, V=0.
- A=111111, B=000001, Op=0 -> S=000000, Cout=1, V=0.
REQ-028 N=6 overflow scenarios:
- A=011011 (27), B=010101 (21), Op=0 -> S=110000, Cout=0, V=1.
- A=110001, B=001001, Op=1 -> S=101000, Cout=1, V=0.
REQ-029 Streaming: run the REQ-027 vectors on consecutive edges -> three consecutive out_valid=1 cycles with results in order, then out_valid=0 with S held.
REQ-030 Reset mid-stream: assert rst for one edge while in_valid=1 -> S=0, Cout=0, V=0, out_valid=0, and the sampled vector is dropped.
REQ-031 Exhaustive/random check at N=6 against a reference model: all 2^13 (A, B, Op) combinations -> S, Cout and V match REQ-013 to REQ-016.
